// File: rtl/dram_pkg.sv
// Shared types and address map for the DRAM AXI-lite slave.
// Address window, response codes and FSM state encoding.
package dram_pkg;

   localparam logic [16:0] DRAM_BASE = 17'h10000;
   localparam logic [16:0] DRAM_LAST = 17'h107F8;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } Resp_t;

   typedef enum logic [2:0] {
      IDLE,
      R_LAT_WAIT,
      R_SEND,
      W_DATA_WAIT,
      B_LAT_WAIT,
      B_SEND
   } Dram_state_t;

   function automatic logic addr_legal(input logic [16:0] a);
      return (a >= DRAM_BASE) && (a <= DRAM_LAST) && (a[2:0] == 3'b000);
   endfunction

endpackage

// File: rtl/dram_axi_slave_if.sv
// AXI-lite style AR/R/AW/W/B bundle between controller and DRAM.
// Master drives requests, slave drives ready/valid responses.
interface dram_axi_slave_if;

   logic        AR_VALID;
   logic [16:0] AR_ADDR;
   logic        AR_READY;
   logic        R_VALID;
   logic [63:0] R_DATA;
   logic [1:0]  R_RESP;
   logic        R_READY;
   logic        AW_VALID;
   logic [16:0] AW_ADDR;
   logic        AW_READY;
   logic        W_VALID;
   logic [63:0] W_DATA;
   logic        W_READY;
   logic        B_VALID;
   logic [1:0]  B_RESP;
   logic        B_READY;

   modport master (
      output AR_VALID, AR_ADDR, R_READY,
      output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
      input  AR_READY, R_VALID, R_DATA, R_RESP,
      input  AW_READY, W_READY, B_VALID, B_RESP
   );

   modport slave (
      input  AR_VALID, AR_ADDR, R_READY,
      input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
      output AR_READY, R_VALID, R_DATA, R_RESP,
      output AW_READY, W_READY, B_VALID, B_RESP
   );

endinterface

// File: rtl/dram_lat_timer.sv
// Loadable 4-bit down-counter pacing read and write-response latency.
// done_o marks the last waiting cycle so the next edge can raise VALID.
module dram_lat_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   output logic       done_o
);

   logic [3:0] cnt_q, cnt_d;

   // Reload on request, otherwise count down and rest at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != 4'd0)
         cnt_d = cnt_q - 4'd1;
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= 4'd0;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q <= 4'd1);

endmodule

// File: rtl/dram_axi_slave.sv
// Single-outstanding AXI-lite DRAM slave, 64-bit entries, preload port.
// Read and write paths share one latency timer since they never overlap.
module dram_axi_slave
   import dram_pkg::*;
#(
   parameter int R_LAT = 4,
   parameter int B_LAT = 2,
   parameter int DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   dram_axi_slave_if.slave   bus,
   input  logic              ld_valid,
   input  logic [7:0]        ld_idx,
   input  logic [63:0]       ld_data,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt
);

   logic [63:0] mem [DEPTH];

   Dram_state_t state_q, state_d;
   logic [16:0] addr_q, addr_d;
   logic        ar_ready_q, ar_ready_d;
   logic        w_ready_q, w_ready_d;
   logic        r_valid_q, r_valid_d;
   logic        b_valid_q, b_valid_d;
   logic [63:0] r_data_q, r_data_d;
   Resp_t       r_resp_q, r_resp_d;
   Resp_t       b_resp_q, b_resp_d;
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;

   logic        ar_hs, aw_hs, aw_ready;
   logic        tmr_load, tmr_done;
   logic [3:0]  tmr_val;
   logic        mem_we;
   logic [7:0]  mem_idx;
   logic [63:0] mem_wd;
   logic        legal_d;

   assign aw_ready = ar_ready_q & ~bus.AR_VALID;
   assign ar_hs    = ar_ready_q & bus.AR_VALID;
   assign aw_hs    = aw_ready & bus.AW_VALID;

   dram_lat_timer u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   // Next-state, memory write strobe and registered-output targets
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      r_data_d = r_data_q;
      r_resp_d = r_resp_q;
      b_resp_d = b_resp_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      tmr_load = 1'b0;
      tmr_val  = 4'(R_LAT - 1);
      mem_we   = 1'b0;
      mem_idx  = ld_idx;
      mem_wd   = ld_data;
      unique case (state_q)
         IDLE: begin
            if (ar_hs) begin
               addr_d   = bus.AR_ADDR;
               tmr_load = 1'b1;
               state_d  = (R_LAT == 1) ? R_SEND : R_LAT_WAIT;
            end else if (aw_hs) begin
               addr_d  = bus.AW_ADDR;
               state_d = W_DATA_WAIT;
            end else if (ld_valid) begin
               mem_we = 1'b1;
            end
         end
         R_LAT_WAIT: begin
            if (tmr_done)
               state_d = R_SEND;
         end
         R_SEND: begin
            if (r_valid_q && bus.R_READY) begin
               state_d = IDLE;
               if (rd_cnt_q != 16'hFFFF)
                  rd_cnt_d = rd_cnt_q + 16'd1;
            end
         end
         W_DATA_WAIT: begin
            if (w_ready_q && bus.W_VALID) begin
               mem_we   = addr_legal(addr_q);
               mem_idx  = addr_q[10:3];
               mem_wd   = bus.W_DATA;
               tmr_load = 1'b1;
               tmr_val  = 4'(B_LAT - 1);
               state_d  = (B_LAT == 1) ? B_SEND : B_LAT_WAIT;
            end
         end
         B_LAT_WAIT: begin
            if (tmr_done)
               state_d = B_SEND;
         end
         B_SEND: begin
            if (b_valid_q && bus.B_READY) begin
               state_d = IDLE;
               if (wr_cnt_q != 16'hFFFF)
                  wr_cnt_d = wr_cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      legal_d = addr_legal(addr_d);
      if (state_d == R_SEND && state_q != R_SEND) begin
         r_data_d = legal_d ? mem[addr_d[10:3]] : 64'd0;
         r_resp_d = legal_d ? OKAY : SLVERR;
      end
      if (state_d == B_SEND && state_q != B_SEND)
         b_resp_d = legal_d ? OKAY : SLVERR;

      ar_ready_d = (state_d == IDLE);
      w_ready_d  = (state_d == W_DATA_WAIT);
      r_valid_d  = (state_d == R_SEND);
      b_valid_d  = (state_d == B_SEND);
   end

   // FSM state and registered bus outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         ar_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         r_valid_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         r_data_q   <= '0;
         r_resp_q   <= OKAY;
         b_resp_q   <= OKAY;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         ar_ready_q <= ar_ready_d;
         w_ready_q  <= w_ready_d;
         r_valid_q  <= r_valid_d;
         b_valid_q  <= b_valid_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         b_resp_q   <= b_resp_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   // Storage array keeps its contents across reset
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_idx] <= mem_wd;
   end

   assign bus.AR_READY = ar_ready_q;
   assign bus.AW_READY = aw_ready;
   assign bus.W_READY  = w_ready_q;
   assign bus.R_VALID  = r_valid_q;
   assign bus.R_DATA   = r_data_q;
   assign bus.R_RESP   = r_resp_q;
   assign bus.B_VALID  = b_valid_q;
   assign bus.B_RESP   = b_resp_q;
   assign rd_cnt       = rd_cnt_q;
   assign wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_dram_axi_slave.sv
// Randomized self-checking bench for dram_axi_slave.
// Reference model: flat 256-entry array plus address-window arithmetic.
module tb_dram_axi_slave;

   localparam int RL = 4;
   localparam int BL = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_valid;
   logic [7:0]  ld_idx;
   logic [63:0] ld_data;
   logic [15:0] rd_cnt;
   logic [15:0] wr_cnt;

   dram_axi_slave_if bus ();

   dram_axi_slave #(
      .R_LAT (RL),
      .B_LAT (BL),
      .DEPTH (256)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .ld_valid (ld_valid),
      .ld_idx   (ld_idx),
      .ld_data  (ld_data),
      .rd_cnt   (rd_cnt),
      .wr_cnt   (wr_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int rd_exp = 0;
   int wr_exp = 0;
   logic [63:0] mdl [256];

   function automatic logic m_legal(input logic [16:0] a);
      int v;
      v = int'(a);
      return (v >= 65536) && (v <= 65536 + 255 * 8) && (v % 8 == 0);
   endfunction

   function automatic logic [7:0] m_idx(input logic [16:0] a);
      int v;
      v = (int'(a) - 65536) / 8;
      return 8'(v);
   endfunction

   function automatic logic [16:0] rand_addr();
      logic [16:0] a;
      int k;
      k = $urandom_range(0, 7);
      a = 17'h10000 + {6'd0, 8'($urandom_range(0, 255)), 3'd0};
      if (k == 5)
         a = a + 17'($urandom_range(1, 7));
      else if (k == 6)
         a = 17'h10800 + {6'd0, 8'($urandom_range(0, 255)), 3'd0};
      else if (k == 7)
         a = 17'($urandom_range(0, 65535));
      return a;
   endfunction

   task automatic idle_inputs();
      bus.AR_VALID = 1'b0;
      bus.AR_ADDR  = '0;
      bus.R_READY  = 1'b0;
      bus.AW_VALID = 1'b0;
      bus.AW_ADDR  = '0;
      bus.W_VALID  = 1'b0;
      bus.W_DATA   = '0;
      bus.B_READY  = 1'b0;
      ld_valid     = 1'b0;
      ld_idx       = '0;
      ld_data      = '0;
   endtask

   task automatic preload(input logic [7:0] i, input logic [63:0] d);
      ld_valid = 1'b1;
      ld_idx   = i;
      ld_data  = d;
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      mdl[i] = d;
   endtask

   task automatic do_read(input logic [16:0] a, output logic [63:0] d,
                          output logic [1:0] r, output int lat);
      int n;
      d = '0;
      r = '0;
      lat = 0;
      bus.AR_VALID = 1'b1;
      bus.AR_ADDR  = a;
      bus.R_READY  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.AR_READY) begin
         n++;
         if (n > 50) begin
            $display("FAIL ar_wait timeout addr=%h", a);
            n_cmp++;
            n_bad++;
            bus.AR_VALID = 1'b0;
            bus.R_READY  = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.AR_VALID = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.R_VALID) begin
         if (lat > 40) begin
            $display("FAIL r_wait timeout addr=%h", a);
            n_cmp++;
            n_bad++;
            bus.R_READY = 1'b0;
            return;
         end
         lat++;
         @(negedge clk);
      end
      d = bus.R_DATA;
      r = bus.R_RESP;
      @(posedge clk);
      #1;
      bus.R_READY = 1'b0;
      rd_exp++;
   endtask

   task automatic do_write(input logic [16:0] a, input logic [63:0] d,
                           input int wdly, input int bhold,
                           output logic [1:0] r, output int boff,
                           output int held);
      int n;
      r = '0;
      boff = 0;
      held = 0;
      bus.AW_VALID = 1'b1;
      bus.AW_ADDR  = a;
      n = 0;
      @(negedge clk);
      while (!bus.AW_READY) begin
         n++;
         if (n > 50) begin
            $display("FAIL aw_wait timeout addr=%h", a);
            n_cmp++;
            n_bad++;
            bus.AW_VALID = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.AW_VALID = 1'b0;
      repeat (wdly) begin
         @(posedge clk);
         #1;
      end
      bus.W_VALID = 1'b1;
      bus.W_DATA  = d;
      n = 0;
      @(negedge clk);
      while (!bus.W_READY) begin
         n++;
         if (n > 50) begin
            $display("FAIL w_wait timeout addr=%h", a);
            n_cmp++;
            n_bad++;
            bus.W_VALID = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.W_VALID = 1'b0;
      if (m_legal(a))
         mdl[m_idx(a)] = d;
      bus.B_READY = 1'b0;
      @(negedge clk);
      while (!bus.B_VALID) begin
         boff++;
         if (boff > 40) begin
            $display("FAIL b_wait timeout addr=%h", a);
            n_cmp++;
            n_bad++;
            return;
         end
         @(negedge clk);
      end
      r = bus.B_RESP;
      for (int i = 0; i < bhold; i++) begin
         if (bus.B_VALID === 1'b1 && bus.B_RESP === r)
            held++;
         @(negedge clk);
      end
      bus.B_READY = 1'b1;
      @(posedge clk);
      #1;
      bus.B_READY = 1'b0;
      wr_exp++;
   endtask

   task automatic test_reset();
      logic [165:0] outs;
      idle_inputs();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      outs = {bus.AR_READY, bus.AW_READY, bus.W_READY, bus.R_VALID,
              bus.B_VALID, bus.R_DATA, bus.R_RESP, bus.B_RESP,
              rd_cnt, wr_cnt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
      n_cmp++;
      if (outs !== '0) begin
         $display("FAIL reset_outputs got=%h want=0", outs);
         n_bad++;
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.AR_READY, bus.AW_READY} !== 2'b00) begin
         $display("FAIL reset_ready_held got=%b want=00",
                  {bus.AR_READY, bus.AW_READY});
         n_bad++;
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.AR_READY, bus.AW_READY} !== 2'b11) begin
         $display("FAIL idle_ready got=%b want=11",
                  {bus.AR_READY, bus.AW_READY});
         n_bad++;
      end
   endtask

   task automatic test_preload_read();
      logic [63:0] d;
      logic [1:0] r;
      int lat;
      preload(8'd5, 64'h0123_4567_89AB_CDEF);
      do_read(17'h10028, d, r, lat);
      n_cmp++;
      if (lat !== RL) begin
         $display("FAIL pr_latency got=%0d want=%0d", lat, RL);
         n_bad++;
      end
      n_cmp++;
      if (d !== 64'h0123_4567_89AB_CDEF) begin
         $display("FAIL pr_data got=%h want=%h", d,
                  64'h0123_4567_89AB_CDEF);
         n_bad++;
      end
      n_cmp++;
      if (r !== 2'b00) begin
         $display("FAIL pr_resp got=%b want=00", r);
         n_bad++;
      end
      n_cmp++;
      if (rd_cnt !== 16'(rd_exp)) begin
         $display("FAIL pr_rd_cnt got=%0d want=%0d", rd_cnt, rd_exp);
         n_bad++;
      end
   endtask

   task automatic test_write_read();
      logic [63:0] d;
      logic [1:0] r;
      int lat, boff, held;
      do_write(17'h107F8, 64'hFFF0_0A00_1230_000C, 3, 5, r, boff, held);
      n_cmp++;
      if (boff !== BL - 1) begin
         $display("FAIL wr_b_offset got=%0d want=%0d", boff, BL - 1);
         n_bad++;
      end
      n_cmp++;
      if (held !== 5) begin
         $display("FAIL wr_b_held got=%0d want=5", held);
         n_bad++;
      end
      n_cmp++;
      if (r !== 2'b00) begin
         $display("FAIL wr_b_resp got=%b want=00", r);
         n_bad++;
      end
      do_read(17'h107F8, d, r, lat);
      n_cmp++;
      if (d !== mdl[255] || r !== 2'b00) begin
         $display("FAIL wr_readback got=%h/%b want=%h/00", d, r, mdl[255]);
         n_bad++;
      end
      n_cmp++;
      if (wr_cnt !== 16'(wr_exp)) begin
         $display("FAIL wr_cnt got=%0d want=%0d", wr_cnt, wr_exp);
         n_bad++;
      end
   endtask

   task automatic test_illegal();
      logic [63:0] d;
      logic [1:0] r;
      int lat, boff, held;
      preload(8'd0, 64'hA5A5_0000_1111_2222);
      do_read(17'h0FFF8, d, r, lat);
      n_cmp++;
      if (d !== 64'd0 || r !== 2'b10) begin
         $display("FAIL ill_read got=%h/%b want=0/10", d, r);
         n_bad++;
      end
      do_write(17'h10004, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, r, boff, held);
      n_cmp++;
      if (r !== 2'b10) begin
         $display("FAIL ill_write_resp got=%b want=10", r);
         n_bad++;
      end
      do_read(17'h10000, d, r, lat);
      n_cmp++;
      if (d !== 64'hA5A5_0000_1111_2222 || r !== 2'b00) begin
         $display("FAIL ill_mem_kept got=%h/%b want=%h/00", d, r,
                  64'hA5A5_0000_1111_2222);
         n_bad++;
      end
   endtask

   task automatic test_simultaneous();
      logic [63:0] d;
      logic [1:0] r;
      int lat, boff, held, bad_aw, n;
      preload(8'd7, 64'h7777_0000_7777_0000);
      bus.AR_VALID = 1'b1;
      bus.AR_ADDR  = 17'h10038;
      bus.R_READY  = 1'b1;
      bus.AW_VALID = 1'b1;
      bus.AW_ADDR  = 17'h10040;
      @(negedge clk);
      n_cmp++;
      if ({bus.AR_READY, bus.AW_READY} !== 2'b10) begin
         $display("FAIL sim_arb got=%b want=10",
                  {bus.AR_READY, bus.AW_READY});
         n_bad++;
      end
      @(posedge clk);
      #1;
      bus.AR_VALID = 1'b0;
      bad_aw = 0;
      n = 0;
      @(negedge clk);
      while (!bus.R_VALID && n < 40) begin
         if (bus.AW_READY !== 1'b0)
            bad_aw++;
         n++;
         @(negedge clk);
      end
      if (bus.AW_READY !== 1'b0)
         bad_aw++;
      d = bus.R_DATA;
      @(posedge clk);
      #1;
      bus.R_READY = 1'b0;
      rd_exp++;
      n_cmp++;
      if (bad_aw !== 0 || d !== mdl[7]) begin
         $display("FAIL sim_read aw_hi=%0d data=%h want=0/%h",
                  bad_aw, d, mdl[7]);
         n_bad++;
      end
      do_write(17'h10040, 64'h0808_0808_0808_0808, 0, 1, r, boff, held);
      do_read(17'h10040, d, r, lat);
      n_cmp++;
      if (d !== 64'h0808_0808_0808_0808) begin
         $display("FAIL sim_write got=%h want=%h", d,
                  64'h0808_0808_0808_0808);
         n_bad++;
      end
   endtask

   task automatic test_reset_mid_read();
      logic [63:0] d;
      logic [1:0] r;
      logic [5:0] outs;
      int lat, seen;
      preload(8'd9, 64'h9999_AAAA_BBBB_CCCC);
      bus.AR_VALID = 1'b1;
      bus.AR_ADDR  = 17'h10048;
      bus.R_READY  = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.AR_VALID = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      outs = {bus.AR_READY, bus.AW_READY, bus.W_READY,
              bus.R_VALID, bus.B_VALID, |{bus.R_DATA, rd_cnt, wr_cnt}};
      n_cmp++;
      if (outs !== 6'd0) begin
         $display("FAIL rst_mid_outputs got=%b want=0", outs);
         n_bad++;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd_exp = 0;
      wr_exp = 0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.R_VALID !== 1'b0)
            seen++;
      end
      bus.R_READY = 1'b0;
      n_cmp++;
      if (seen !== 0) begin
         $display("FAIL rst_mid_no_r got=%0d want=0", seen);
         n_bad++;
      end
      @(posedge clk);
      #1;
      do_read(17'h10048, d, r, lat);
      n_cmp++;
      if (d !== mdl[9] || rd_cnt !== 16'(rd_exp)) begin
         $display("FAIL rst_mid_retain got=%h/%0d want=%h/%0d",
                  d, rd_cnt, mdl[9], rd_exp);
         n_bad++;
      end
   endtask

   task automatic test_preload_blocked();
      logic [63:0] d0, d;
      logic [1:0] r;
      int lat, n;
      preload(8'd12, 64'h1212_3434_5656_7878);
      bus.AR_VALID = 1'b1;
      bus.AR_ADDR  = 17'h10060;
      bus.R_READY  = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.AR_VALID = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bus.R_VALID && n < 40) begin
         n++;
         @(negedge clk);
      end
      d0 = bus.R_DATA;
      ld_valid = 1'b1;
      ld_idx   = 8'd12;
      ld_data  = ~mdl[12];
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.R_VALID !== 1'b1 || bus.R_DATA !== d0 || d0 !== mdl[12]) begin
         $display("FAIL blk_hold got=%b/%h want=1/%h",
                  bus.R_VALID, bus.R_DATA, mdl[12]);
         n_bad++;
      end
      bus.R_READY = 1'b1;
      @(posedge clk);
      #1;
      bus.R_READY = 1'b0;
      rd_exp++;
      do_read(17'h10060, d, r, lat);
      n_cmp++;
      if (d !== mdl[12]) begin
         $display("FAIL blk_entry got=%h want=%h", d, mdl[12]);
         n_bad++;
      end
   endtask

   task automatic test_random();
      logic [63:0] d, wd, ed;
      logic [1:0] r, er;
      logic [16:0] a;
      int lat, boff, held, op, hold;
      for (int i = 0; i < 256; i++)
         preload(8'(i), {$urandom, $urandom});
      for (int k = 0; k < 60; k++) begin
         op = $urandom_range(0, 2);
         a  = rand_addr();
         if (op == 0) begin
            ed = m_legal(a) ? mdl[m_idx(a)] : 64'd0;
            er = m_legal(a) ? 2'b00 : 2'b10;
            do_read(a, d, r, lat);
            n_cmp++;
            if (d !== ed || r !== er || lat !== RL) begin
               $display("FAIL rnd_read a=%h got=%h/%b/%0d want=%h/%b/%0d",
                        a, d, r, lat, ed, er, RL);
               n_bad++;
            end
         end else if (op == 1) begin
            wd   = {$urandom, $urandom};
            hold = $urandom_range(0, 3);
            er   = m_legal(a) ? 2'b00 : 2'b10;
            do_write(a, wd, $urandom_range(0, 3), hold, r, boff, held);
            n_cmp++;
            if (r !== er || boff !== BL - 1 || held !== hold) begin
               $display("FAIL rnd_write a=%h got=%b/%0d/%0d want=%b/%0d/%0d",
                        a, r, boff, held, er, BL - 1, hold);
               n_bad++;
            end
         end else begin
            preload(8'($urandom_range(0, 255)), {$urandom, $urandom});
         end
      end
      n_cmp++;
      if (rd_cnt !== 16'(rd_exp) || wr_cnt !== 16'(wr_exp)) begin
         $display("FAIL rnd_counts got=%0d/%0d want=%0d/%0d",
                  rd_cnt, wr_cnt, rd_exp, wr_exp);
         n_bad++;
      end
   endtask

   initial begin
      test_reset();
      test_preload_read();
      test_write_read();
      test_illegal();
      test_simultaneous();
      test_reset_mid_read();
      test_preload_blocked();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
